sfp_norm: RTL and testbench

- Special-function stage directly downstream of the dual-core controller. Driven by its SFP instruction bits: accumulate, divide, and pmem write-back.
- Takes one P-memory row of COL signed psums and computes the absolute-value sum of the row.
- Exchanges that partial sum with the peer core, then divides every element by the total to produce a normalized fixed-point row for write-back to pmem.

---
 rtl/sfp_norm.sv | 199 +++++++++++++++++++
 tb/tb_sfp_norm.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sfp_norm.sv
// sfp_norm: special-function stage for one pmem row.
// Accumulates the absolute values of COL signed psums, exchanges the partial
// sum with the peer core, then divides every element by the total using COL
// parallel restoring dividers to give a signed fixed-point normalised row.
// Optional feature macro: SFP_DUAL_CORE_EN (defined: total = local + peer sum;
// undefined: total = local sum only, sum_in ignored).
module sfp_norm #(
    parameter int COL     = 8,
    parameter int PSUM_BW = 16,
    parameter int FRAC    = 8,
    parameter int SUM_BW  = PSUM_BW + $clog2(COL)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [COL*PSUM_BW-1:0]   sfp_in,
    input  logic                     acc,
    input  logic                     div,
    input  logic [SUM_BW-1:0]        sum_in,
    output logic [SUM_BW-1:0]        sum_out,
    output logic [COL*PSUM_BW-1:0]   sfp_out,
    output logic                     out_valid,
    output logic                     sfp_ready,
    output logic                     div_zero
);

    // quotient/dividend width, total width, remainder-shift width, step counter width
    localparam int QW    = PSUM_BW + FRAC;
    localparam int TW    = SUM_BW + 1;
    localparam int REM_W = TW + 1;
    localparam int CW    = $clog2(QW);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ABS  = 3'd1,
        S_SUM  = 3'd2,
        S_HOLD = 3'd3,
        S_DIV  = 3'd4,
        S_OUT  = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [PSUM_BW-1:0]   r_mag   [COL];
    logic [COL-1:0]       r_sign;
    logic [TW-1:0]        r_total;
    logic [CW-1:0]        r_cnt;
    logic [TW-1:0]        r_rem   [COL];
    logic [QW-1:0]        r_quo   [COL];
    logic                 r_ready;

    logic [PSUM_BW-1:0]   w_elem  [COL];
    logic [PSUM_BW-1:0]   w_abs   [COL];
    logic [SUM_BW-1:0]    w_sum;
    logic [TW-1:0]        w_total;
    logic [REM_W-1:0]     w_shift [COL];
    logic [REM_W-1:0]     w_diff  [COL];
    logic [TW-1:0]        w_rem_nx[COL];
    logic [QW-1:0]        w_quo_nx[COL];
    logic [PSUM_BW-1:0]   w_q     [COL];
    logic [COL*PSUM_BW-1:0] w_res;
    logic                 w_acc_go;
    logic                 w_div_go;
    logic                 w_tot_zero;
    logic                 w_finish;

    // acc is honoured only in IDLE/HOLD; div only in HOLD and loses to a simultaneous acc
    assign w_acc_go   = acc && ((r_state == S_IDLE) || (r_state == S_HOLD));
    assign w_div_go   = div && !acc && (r_state == S_HOLD);
    assign w_tot_zero = (r_total == {TW{1'b0}});
    assign w_finish   = (r_state == S_DIV) && (w_next == S_OUT);
    assign sfp_ready  = r_ready;

`ifdef SFP_DUAL_CORE_EN
    assign w_total = {1'b0, sum_out} + {1'b0, sum_in};
`else
    logic w_sum_in_unused;
    assign w_sum_in_unused = ^sum_in;
    assign w_total = {1'b0, sum_out};
`endif

    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (acc) w_next = S_ABS;
                else     w_next = S_IDLE;
            end
            S_ABS:  w_next = S_SUM;
            S_SUM:  w_next = S_HOLD;
            S_HOLD: begin
                if (acc)      w_next = S_ABS;
                else if (div) w_next = S_DIV;
                else          w_next = S_HOLD;
            end
            S_DIV: begin
                if (w_tot_zero)                    w_next = S_OUT;
                else if (r_cnt == CW'(QW - 1))     w_next = S_OUT;
                else                               w_next = S_DIV;
            end
            S_OUT:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // element magnitudes; the most-negative value maps to 2^(PSUM_BW-1) unsigned
    always_comb begin
        for (int i = 0; i < COL; i++) begin
            w_elem[i] = sfp_in[i*PSUM_BW +: PSUM_BW];
            if (w_elem[i][PSUM_BW-1]) w_abs[i] = ~w_elem[i] + PSUM_BW'(1);
            else                      w_abs[i] = w_elem[i];
        end
    end

    // sum of the latched magnitudes
    always_comb begin
        w_sum = {SUM_BW{1'b0}};
        for (int i = 0; i < COL; i++) begin
            w_sum = w_sum + SUM_BW'(r_mag[i]);
        end
    end

    // one restoring-division step per element; diff MSB clear means shift >= total
    always_comb begin
        w_res = {(COL*PSUM_BW){1'b0}};
        for (int i = 0; i < COL; i++) begin
            w_shift[i] = {r_rem[i], r_quo[i][QW-1]};
            w_diff[i]  = w_shift[i] - {1'b0, r_total};
            if (!w_diff[i][REM_W-1]) begin
                w_rem_nx[i] = w_diff[i][TW-1:0];
                w_quo_nx[i] = {r_quo[i][QW-2:0], 1'b1};
            end else begin
                w_rem_nx[i] = w_shift[i][TW-1:0];
                w_quo_nx[i] = {r_quo[i][QW-2:0], 1'b0};
            end
            w_q[i] = w_quo_nx[i][PSUM_BW-1:0];
            if (r_sign[i]) w_res[i*PSUM_BW +: PSUM_BW] = PSUM_BW'(0) - w_q[i];
            else           w_res[i*PSUM_BW +: PSUM_BW] = w_q[i];
        end
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < COL; i++) begin
                r_mag[i] <= {PSUM_BW{1'b0}};
                r_rem[i] <= {TW{1'b0}};
                r_quo[i] <= {QW{1'b0}};
            end
            r_sign    <= {COL{1'b0}};
            r_total   <= {TW{1'b0}};
            r_cnt     <= {CW{1'b0}};
            r_ready   <= 1'b1;
            sum_out   <= {SUM_BW{1'b0}};
            sfp_out   <= {(COL*PSUM_BW){1'b0}};
            out_valid <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            if (w_acc_go) begin
                for (int i = 0; i < COL; i++) begin
                    r_mag[i]  <= w_abs[i];
                    r_sign[i] <= sfp_in[i*PSUM_BW + PSUM_BW - 1];
                end
            end
            if (r_state == S_ABS) begin
                sum_out <= w_sum;
            end
            if (w_div_go) begin
                r_total  <= w_total;
                r_cnt    <= {CW{1'b0}};
                div_zero <= 1'b0;
                for (int i = 0; i < COL; i++) begin
                    r_rem[i] <= {TW{1'b0}};
                    r_quo[i] <= {r_mag[i], {FRAC{1'b0}}};
                end
            end else if ((r_state == S_DIV) && !w_tot_zero) begin
                r_cnt <= r_cnt + CW'(1);
                for (int i = 0; i < COL; i++) begin
                    r_rem[i] <= w_rem_nx[i];
                    r_quo[i] <= w_quo_nx[i];
                end
            end
            if (w_finish) begin
                sfp_out  <= w_tot_zero ? {(COL*PSUM_BW){1'b0}} : w_res;
                div_zero <= w_tot_zero;
            end
            out_valid <= w_finish;
            r_ready   <= (w_next == S_IDLE);
        end
    end

endmodule

// File: tb/tb_sfp_norm.sv
// Directed scoreboard bench for sfp_norm: expected rows come from a behavioural
// model pushed at each div and popped when out_valid is seen.
module tb_sfp_norm;

    localparam int COL     = 8;
    localparam int PSUM_BW = 16;
    localparam int FRAC    = 8;
    localparam int SUM_BW  = 19;
    localparam int RW      = COL * PSUM_BW;

    logic              clk = 1'b0;
    logic              reset;
    logic [RW-1:0]     sfp_in;
    logic              acc;
    logic              div;
    logic [SUM_BW-1:0] sum_in;
    logic [SUM_BW-1:0] sum_out;
    logic [RW-1:0]     sfp_out;
    logic              out_valid;
    logic              sfp_ready;
    logic              div_zero;

    int n_vec = 0;
    int n_err = 0;

    logic [RW-1:0] exp_q[$];
    bit            dz_q[$];

    localparam logic [RW-1:0] ROW_A = {16'd128, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'hFFC0, 16'd64};
    localparam logic [RW-1:0] ROW_Z = {RW{1'b0}};
    localparam logic [RW-1:0] ROW_N = {112'd0, 16'h8000};
    localparam logic [RW-1:0] ROW_B = {16'd1000, 16'hFC18, 16'd3, 16'hFFFF, 16'd7, 16'd0, 16'd250, 16'h7FFF};
    localparam logic [RW-1:0] ROW_C = {16'h0123, 16'hF000, 16'h0800, 16'h8001, 16'h0001, 16'h00FF, 16'hFF01, 16'h4000};

    always #5 clk = ~clk;

    sfp_norm #(.COL(COL), .PSUM_BW(PSUM_BW), .FRAC(FRAC), .SUM_BW(SUM_BW)) dut (
        .clk       (clk),
        .reset     (reset),
        .sfp_in    (sfp_in),
        .acc       (acc),
        .div       (div),
        .sum_in    (sum_in),
        .sum_out   (sum_out),
        .sfp_out   (sfp_out),
        .out_valid (out_valid),
        .sfp_ready (sfp_ready),
        .div_zero  (div_zero)
    );

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [SUM_BW-1:0] model_sum(input logic [RW-1:0] row);
        longint tot;
        logic [15:0] x;
        tot = 0;
        for (int i = 0; i < COL; i++) begin
            x = row[i*PSUM_BW +: PSUM_BW];
            tot += x[15] ? (longint'(65536) - longint'(x)) : longint'(x);
        end
        return tot[SUM_BW-1:0];
    endfunction

    function automatic logic [RW-1:0] model_row(input logic [RW-1:0] row, input logic [SUM_BW-1:0] sin, output bit dz);
        longint tot, mag, q, e;
        logic [15:0] x;
        logic [RW-1:0] r;
        tot = longint'(model_sum(row));
`ifdef SFP_DUAL_CORE_EN
        tot += longint'(sin);
`endif
        r  = '0;
        dz = (tot == 0);
        if (!dz) begin
            for (int i = 0; i < COL; i++) begin
                x   = row[i*PSUM_BW +: PSUM_BW];
                mag = x[15] ? (longint'(65536) - longint'(x)) : longint'(x);
                q   = (mag << FRAC) / tot;
                e   = x[15] ? -q : q;
                r[i*PSUM_BW +: PSUM_BW] = e[15:0];
            end
        end
        return r;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_sum_out"},   RW'(sum_out),   RW'(0));
        check({tag, "_sfp_out"},   sfp_out,        RW'(0));
        check({tag, "_out_valid"}, RW'(out_valid), RW'(0));
        check({tag, "_sfp_ready"}, RW'(sfp_ready), RW'(1));
        check({tag, "_div_zero"},  RW'(div_zero),  RW'(0));
    endtask

    // acc pulse, then scramble sfp_in; returns in the HOLD cycle
    task automatic acc_seq(input logic [RW-1:0] row);
        sfp_in = row;
        acc    = 1'b1;
        @(negedge clk);
        acc    = 1'b0;
        sfp_in = ~row;
        check("ready_low_abs", RW'(sfp_ready), RW'(0));
        @(negedge clk);
        check("sum_out", RW'(sum_out), RW'(model_sum(row)));
        @(negedge clk);
    endtask

    // div pulse from HOLD; optional acc+div poke at cycle 'poke' of the divide
    task automatic div_seq(input logic [RW-1:0] row, input logic [SUM_BW-1:0] sin, input int exp_lat, input int poke);
        bit            dz;
        int            cnt;
        logic [RW-1:0] e_row;
        bit            e_dz;
        sum_in = sin;
        div    = 1'b1;
        exp_q.push_back(model_row(row, sin, dz));
        dz_q.push_back(dz);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            acc = (cnt == poke);
            div = (cnt == poke);
        end while (!out_valid && cnt < 60);
        acc = 1'b0;
        div = 1'b0;
        check("latency", RW'(cnt), RW'(exp_lat));
        e_row = exp_q.pop_front();
        e_dz  = dz_q.pop_front();
        check("sfp_out", sfp_out, e_row);
        check("div_zero", RW'(div_zero), RW'(e_dz));
        @(negedge clk);
        check("valid_pulse", RW'(out_valid), RW'(0));
        check("ready_idle", RW'(sfp_ready), RW'(1));
        check("out_hold", sfp_out, e_row);
    endtask

    initial begin
        int seen;
        reset  = 1'b1;
        acc    = 1'b0;
        div    = 1'b0;
        sfp_in = '0;
        sum_in = '0;
        #1;
        check_reset_vals("rst_in");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_out");

        // basic row, zero peer sum
        acc_seq(ROW_A);
        div_seq(ROW_A, 19'd0, 25, 0);

        // peer sum of 256 (only affects the total in the dual-core build)
        acc_seq(ROW_A);
        div_seq(ROW_A, 19'd256, 25, 0);

        // all-zero row: short divide, div_zero set
        acc_seq(ROW_Z);
        div_seq(ROW_Z, 19'd0, 2, 0);

        // next divide clears div_zero
        acc_seq(ROW_B);
        div_seq(ROW_B, 19'd0, 25, 0);

        // most-negative element
        acc_seq(ROW_N);
        div_seq(ROW_N, 19'd0, 25, 0);

        // acc+div poked mid-divide are ignored
        acc_seq(ROW_B);
        div_seq(ROW_B, 19'd77, 25, 10);

        // acc+div together in HOLD: re-accumulate only
        acc_seq(ROW_A);
        sfp_in = ROW_C;
        acc    = 1'b1;
        div    = 1'b1;
        @(negedge clk);
        acc    = 1'b0;
        div    = 1'b0;
        sfp_in = '0;
        seen   = 0;
        @(negedge clk);
        check("reacc_sum", RW'(sum_out), RW'(model_sum(ROW_C)));
        for (int k = 0; k < 30; k++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        check("reacc_no_valid", RW'(seen), RW'(0));
        div_seq(ROW_C, 19'd0, 25, 0);

        // async reset ten cycles into a divide
        acc_seq(ROW_B);
        sum_in = 19'd0;
        div    = 1'b1;
        @(negedge clk);
        div = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("rst_mid");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_idle", RW'(sfp_ready), RW'(1));
        acc_seq(ROW_A);
        div_seq(ROW_A, 19'd0, 25, 0);

        check("sb_empty", RW'(exp_q.size()), RW'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
